trig_coax_tx: RTL and testbench
===============================

# trig_coax_tx

Per-board trigger transmitter that drives the coax lines into the distribution board's trigger receiver. In normal running it converts asynchronous per-channel trigger requests into single-tick pulses aligned to a fixed slot of a free-running 4-phase counter. On request it runs a calibration sequence: a quiet gap followed by a sync-pulse burst, which the receiver uses to lock its phase bins. It sits between the board's local discriminator/trigger logic and the coax output drivers.

## Interface
Parameters:
- NCH, 4, number of coax trigger channels
- TX_PHASE, 0, phase-counter value (0..3) on which pulses are launched
- QUIET_TICKS, 220, all-low ticks before the sync burst (receiver ignores its first 200 ticks)
- SYNC_PULSES, 64, sync pulses per burst (receiver locks at 54–55 counts in one bin)
- HOLD_TICKS, 16, per-channel re-arm time after a trigger pulse (covers receiver Tin hold of 4 slots)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clk_adc domain clock
- nrst  in  1  asynchronous active-low reset
- trig_in  in  NCH  per-channel trigger request, level, sampled each clk
- sync_start  in  1  calibration request; rising edge starts a sequence
- coax_out  out  NCH  registered coax drive
- busy  out  1  high while not in RUN state
- sync_done  out  1  one-tick pulse when a burst completes
- dropped_cnt  out  16  saturating count of trigger requests lost to calibration or holdoff
- phase  out  2  free-running phase counter, for monitoring

## Operation
- phase increments every clk, wraps 3→0.
- States: RUN, QUIET, SYNC.
- RUN: for each channel, an armed channel with trig_in high sets pending. On the edge where phase==TX_PHASE, coax_out[ch] <= pending[ch] | (trig_in[ch] & armed[ch]). The same edge clears pending and loads holdoff=HOLD_TICKS for every channel that fired. At all other edges coax_out <= 0.
- Holdoff: counts down to 0 once per clk; the channel is armed only when holdoff==0.
- Counting drops: a trig_in rising edge (edge-detected per channel) on a channel in holdoff increments dropped_cnt by 1 per channel-event. A held-high trig_in counts once.
- sync_start rising edge (registered edge detect) in RUN moves the block to QUIET:
  - quiet counter loaded with QUIET_TICKS.
  - All pending bits cleared; each cleared bit increments dropped_cnt.
- QUIET: coax_out = 0. Decrement each clk; at 0, go to SYNC with pulse counter = SYNC_PULSES.
- SYNC: on each phase==TX_PHASE edge, coax_out <= all ones and the pulse counter decrements; otherwise coax_out <= 0. After the last pulse is launched, go to RUN on the next clk and assert sync_done for 1 tick. Holdoff counters are cleared.
- In QUIET/SYNC, trig_in rising edges increment dropped_cnt. sync_start edges are ignored.
- dropped_cnt saturates at 16'hFFFF. Simultaneous increments in one cycle (several channels) add their popcount, with saturation.

## Timing
- Reset (async assert, sync release): state=RUN, phase=0, coax_out=0, busy=0, sync_done=0, dropped_cnt=0, pending=0, holdoff=0.
- Reset mid-QUIET/SYNC aborts immediately. coax_out is 0 while nrst is low.
- Trigger latency: trig_in high on edge e → coax_out high for exactly 1 tick, starting 1–4 clks after e, always in the cycle following a phase==TX_PHASE edge.
- sync_start edge → busy high 2 clks later (edge register + state register).
- First sync pulse appears QUIET_TICKS + ≤4 clks later. Burst spans 4·SYNC_PULSES clks.
- Default total calibration time ≤ 2+220+4+256 = 482 ticks, which fits inside the receiver's 655-tick window.

## Structure
- Package trig_tx_pkg: state enum (RUN, QUIET, SYNC), default constants, and a saturating-add function for dropped_cnt.
- Sub-module trig_tx_lane, instantiated NCH times: holds pending, holdoff, armed, rising-edge detect, and the fire/drop outputs.
- Top level holds phase, the FSM, quiet/pulse counters and dropped_cnt.

## Test plan
- Reset release, trig_in[2] pulsed 1 clk at phase=1 → coax_out[2] high for exactly the cycle after the next phase==0 edge; other bits stay 0; dropped_cnt=0.
- trig_in[0] retriggered 5 clks after firing → no second pulse; dropped_cnt=1. Retrigger 20 clks after firing → second pulse aligned to phase 0.
- sync_start rising → busy=1, coax_out all 0 for 220 ticks, then 64 all-ones pulses spaced exactly 4 clks apart; sync_done pulses once; busy=0.
- Triggers on all 4 channels during SYNC → no extra coax pulses; dropped_cnt=4. A second sync_start during SYNC is ignored (still exactly 64 pulses).
- Pending trigger on channel 1 when sync_start arrives → pending discarded, dropped_cnt increments by 1.
- dropped_cnt preset near saturation via 65540 drops → reads 65535. nrst asserted mid-burst → coax_out=0 immediately; RUN state after release.

Source files
------------

// File: rtl/trig_tx_pkg.sv
// Shared types, defaults and helpers for the coax trigger transmitter.
package trig_tx_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    QUIET = 2'd1,
    SYNC  = 2'd2
  } tx_state_e;

  localparam int DEF_NCH         = 4;
  localparam int DEF_TX_PHASE    = 0;
  localparam int DEF_QUIET_TICKS = 220;
  localparam int DEF_SYNC_PULSES = 64;
  localparam int DEF_HOLD_TICKS  = 16;

  // Add a small per-cycle increment to the drop counter, pinning at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {9'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/trig_tx_lane.sv
// One trigger channel: pending latch, re-arm holdoff, rising-edge detect,
// and the fire / drop indications consumed by the top level.
module trig_tx_lane
  import trig_tx_pkg::*;
#(
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_trig,       // level trigger request
  input  logic i_run,        // normal running; low flushes the lane
  input  logic i_tx_edge,    // this edge is the launch slot
  output logic o_fire,       // launch a pulse on this edge
  output logic o_drop_rise,  // a new request was lost this edge
  output logic o_drop_pend   // a pending request was discarded this edge
);

  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic          r_trig_d;
  logic          r_pending;
  logic [HW-1:0] r_holdoff;

  logic w_rise;
  logic w_armed;
  logic w_fire;

  assign w_rise  = i_trig & ~r_trig_d;
  assign w_armed = (r_holdoff == '0);
  assign w_fire  = i_run & i_tx_edge & (r_pending | (i_trig & w_armed));

  // Outside normal running every new edge is lost; in running only edges
  // that land inside the holdoff window are lost.
  assign o_fire      = w_fire;
  assign o_drop_rise = w_rise & (~i_run | ~w_armed);
  assign o_drop_pend = ~i_run & r_pending;

  // Pending latch, holdoff countdown and edge-detect history.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_trig_d  <= 1'b0;
      r_pending <= 1'b0;
      r_holdoff <= '0;
    end else begin
      r_trig_d <= i_trig;
      if (!i_run) begin
        r_pending <= 1'b0;
        r_holdoff <= '0;
      end else begin
        if (i_tx_edge) begin
          r_pending <= 1'b0;
        end else if (i_trig && w_armed) begin
          r_pending <= 1'b1;
        end
        if (w_fire) begin
          r_holdoff <= HW'(HOLD_TICKS);
        end else if (!w_armed) begin
          r_holdoff <= r_holdoff - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/trig_coax_tx.sv
// Coax trigger transmitter: phase-aligned trigger pulses in normal running,
// quiet gap plus sync burst on a calibration request, saturating drop count.
module trig_coax_tx
  import trig_tx_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int TX_PHASE    = DEF_TX_PHASE,
  parameter int QUIET_TICKS = DEF_QUIET_TICKS,
  parameter int SYNC_PULSES = DEF_SYNC_PULSES,
  parameter int HOLD_TICKS  = DEF_HOLD_TICKS
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [NCH-1:0]   trig_in,
  input  logic             sync_start,
  output logic [NCH-1:0]   coax_out,
  output logic             busy,
  output logic             sync_done,
  output logic [15:0]      dropped_cnt,
  output logic [1:0]       phase
);

  tx_state_e      r_state;
  tx_state_e      w_state_next;
  logic [1:0]     r_phase;
  logic           r_sync_d;
  logic           r_sync_edge;
  logic [15:0]    r_quiet;
  logic [15:0]    w_quiet_next;
  logic [15:0]    r_pulse;
  logic [15:0]    w_pulse_next;
  logic [NCH-1:0] r_coax;
  logic [NCH-1:0] w_coax_next;
  logic           r_sync_done;
  logic           w_sync_done_next;
  logic [15:0]    r_dropped;
  logic [7:0]     w_drop_inc;

  logic           w_tx_edge;
  logic           w_lane_run;
  logic [NCH-1:0] w_fire;
  logic [NCH-1:0] w_drop_rise;
  logic [NCH-1:0] w_drop_pend;

  assign w_tx_edge = (r_phase == 2'(TX_PHASE));
  // The edge that leaves RUN already flushes the lanes so a pending request
  // is counted as dropped rather than launched.
  assign w_lane_run = (r_state == RUN) && !r_sync_edge;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      trig_tx_lane #(
        .HOLD_TICKS(HOLD_TICKS)
      ) u_lane (
        .clk         (clk),
        .nrst        (nrst),
        .i_trig      (trig_in[gi]),
        .i_run       (w_lane_run),
        .i_tx_edge   (w_tx_edge),
        .o_fire      (w_fire[gi]),
        .o_drop_rise (w_drop_rise[gi]),
        .o_drop_pend (w_drop_pend[gi])
      );
    end
  endgenerate

  // Free-running 4-phase slot counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_phase <= 2'd0;
    else       r_phase <= r_phase + 2'd1;
  end

  // Registered rising-edge detect of the calibration request.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync_d    <= 1'b0;
      r_sync_edge <= 1'b0;
    end else begin
      r_sync_d    <= sync_start;
      r_sync_edge <= sync_start & ~r_sync_d;
    end
  end

  // Next state, counters and coax drive for the calibration sequencer.
  always_comb begin
    w_state_next     = r_state;
    w_quiet_next     = r_quiet;
    w_pulse_next     = r_pulse;
    w_coax_next      = '0;
    w_sync_done_next = 1'b0;
    case (r_state)
      RUN: begin
        w_coax_next = w_fire;
        if (r_sync_edge) begin
          w_state_next = QUIET;
          w_quiet_next = 16'(QUIET_TICKS);
        end
      end
      QUIET: begin
        if (r_quiet <= 16'd1) begin
          w_state_next = SYNC;
          w_quiet_next = 16'd0;
          w_pulse_next = 16'(SYNC_PULSES);
        end else begin
          w_quiet_next = r_quiet - 16'd1;
        end
      end
      SYNC: begin
        if (r_pulse == 16'd0) begin
          w_state_next     = RUN;
          w_sync_done_next = 1'b1;
        end else if (w_tx_edge) begin
          w_coax_next  = '1;
          w_pulse_next = r_pulse - 16'd1;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  // Count of requests lost this cycle across all lanes.
  always_comb begin
    w_drop_inc = 8'd0;
    for (int i = 0; i < NCH; i++) begin
      w_drop_inc = w_drop_inc + 8'(w_drop_rise[i]) + 8'(w_drop_pend[i]);
    end
  end

  // Sequencer state and its counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= RUN;
      r_quiet <= 16'd0;
      r_pulse <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_quiet <= w_quiet_next;
      r_pulse <= w_pulse_next;
    end
  end

  // Registered outputs and the saturating drop counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_coax      <= '0;
      r_sync_done <= 1'b0;
      r_dropped   <= 16'd0;
    end else begin
      r_coax      <= w_coax_next;
      r_sync_done <= w_sync_done_next;
      r_dropped   <= sat_add16(r_dropped, w_drop_inc);
    end
  end

  assign coax_out    = r_coax;
  assign busy        = (r_state != RUN);
  assign sync_done   = r_sync_done;
  assign dropped_cnt = r_dropped;
  assign phase       = r_phase;

endmodule

// File: tb/tb_trig_coax_tx.sv
// Scoreboard bench for trig_coax_tx: an edge-indexed reference model pushes
// expected coax pulses and sync_done events; a monitor pops and compares.
module tb_trig_coax_tx;

  localparam int NCH = 4;
  localparam int TX  = 0;
  localparam int QT  = 220;
  localparam int SP  = 64;
  localparam int HT  = 16;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic [NCH-1:0] trig_in = '0;
  logic           sync_start = 1'b0;
  logic [NCH-1:0] coax_out;
  logic           busy;
  logic           sync_done;
  logic [15:0]    dropped_cnt;
  logic [1:0]     phase;

  trig_coax_tx #(
    .NCH(NCH), .TX_PHASE(TX), .QUIET_TICKS(QT), .SYNC_PULSES(SP), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .nrst(nrst), .trig_in(trig_in), .sync_start(sync_start),
    .coax_out(coax_out), .busy(busy), .sync_done(sync_done),
    .dropped_cnt(dropped_cnt), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int             edge_n;
    logic [NCH-1:0] val;
  } ev_t;

  ev_t            coax_q[$];
  int             done_q[$];
  int             n;                // index of the last clock edge since reset release
  logic [NCH-1:0] m_prev_t;
  logic           m_prev_ss;
  logic           m_ss_edge;
  logic [NCH-1:0] m_pend;
  int             m_last_fire[NCH];
  logic           m_in_cal;
  int             m_cal_t0;
  int             m_pulses;
  int             m_drop;
  longint         m_raw;

  task automatic model_reset();
    n = -1; m_prev_t = '0; m_prev_ss = 1'b0; m_ss_edge = 1'b0; m_pend = '0;
    for (int c = 0; c < NCH; c++) m_last_fire[c] = -1000;
    m_in_cal = 1'b0; m_cal_t0 = 0; m_pulses = 0; m_drop = 0; m_raw = 0;
    coax_q.delete(); done_q.delete();
  endtask

  initial begin
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fire;
    int             inc;
    bit             armed;
    model_reset();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        model_reset();
      end else begin
        n++;
        rise = trig_in & ~m_prev_t;
        fire = '0;
        inc  = 0;
        if (!m_in_cal && m_ss_edge) begin
          // calibration begins: pending requests and same-edge requests are lost
          for (int c = 0; c < NCH; c++) begin
            inc += int'(m_pend[c]) + int'(rise[c]);
            m_last_fire[c] = -1000;
          end
          m_pend = '0; m_in_cal = 1'b1; m_cal_t0 = n; m_pulses = 0;
        end else if (!m_in_cal) begin
          for (int c = 0; c < NCH; c++) begin
            armed = (n - m_last_fire[c]) > HT;
            if (rise[c] && !armed) inc++;
            if ((n % 4) == TX) begin
              if (m_pend[c] || (trig_in[c] && armed)) begin
                fire[c] = 1'b1;
                m_last_fire[c] = n;
              end
              m_pend[c] = 1'b0;
            end else if (trig_in[c] && armed) begin
              m_pend[c] = 1'b1;
            end
          end
        end else begin
          inc = $countones(rise);
          if (n > m_cal_t0 + QT) begin
            if (m_pulses == SP) begin
              m_in_cal = 1'b0;
              done_q.push_back(n);
            end else if ((n % 4) == TX) begin
              m_pulses++;
              fire = '1;
            end
          end
        end
        if (fire != '0) coax_q.push_back('{edge_n: n, val: fire});
        m_raw  += inc;
        m_drop  = (m_drop + inc > 65535) ? 65535 : m_drop + inc;
        m_ss_edge = sync_start & ~m_prev_ss;
        m_prev_ss = sync_start;
        m_prev_t  = trig_in;
      end
    end
  end

  // ---------------- monitor ----------------
  int pulse_cnt[NCH];
  int burst_cnt = 0;
  int done_cnt = 0;

  initial begin
    for (int c = 0; c < NCH; c++) pulse_cnt[c] = 0;
    forever begin
      @(negedge clk);
      if (nrst) begin
        while (coax_q.size() > 0 && coax_q[0].edge_n < n) begin
          checks++; errors++;
          $display("FAIL coax_missing: edge %0d got none expected %b", coax_q[0].edge_n, coax_q[0].val);
          void'(coax_q.pop_front());
        end
        if (coax_out != '0) begin
          for (int c = 0; c < NCH; c++) if (coax_out[c]) pulse_cnt[c]++;
          if (&coax_out) burst_cnt++;
          if (coax_q.size() > 0 && coax_q[0].edge_n == n) begin
            chk("coax_value", coax_out, coax_q[0].val);
            void'(coax_q.pop_front());
          end else begin
            checks++; errors++;
            $display("FAIL coax_unexpected: edge %0d got %b expected 0", n, coax_out);
          end
        end else if (coax_q.size() > 0 && coax_q[0].edge_n == n) begin
          checks++; errors++;
          $display("FAIL coax_missing: edge %0d got 0 expected %b", n, coax_q[0].val);
          void'(coax_q.pop_front());
        end
        while (done_q.size() > 0 && done_q[0] < n) begin
          checks++; errors++;
          $display("FAIL sync_done_missing: edge %0d got 0 expected 1", done_q[0]);
          void'(done_q.pop_front());
        end
        if (sync_done) begin
          done_cnt++;
          checks++;
          if (done_q.size() > 0 && done_q[0] == n) begin
            void'(done_q.pop_front());
          end else begin
            errors++;
            $display("FAIL sync_done_unexpected: edge %0d got 1 expected 0", n);
          end
        end else if (done_q.size() > 0 && done_q[0] == n) begin
          checks++; errors++;
          $display("FAIL sync_done_missing: edge %0d got 0 expected 1", n);
          void'(done_q.pop_front());
        end
        chk("busy", busy, m_in_cal);
        chk("phase", phase, (n + 1) % 4);
        chk("dropped_cnt", dropped_cnt, m_drop);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_phase(input int want);
    while (((n + 1) % 4) != want) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    chk("wait_idle_busy", busy, 0);
  endtask

  task automatic random_cycles(input int cycles, input int sync_odds);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      trig_in    = trig_in ^ (NCH'($urandom) & NCH'($urandom) & NCH'($urandom));
      sync_start = ($urandom_range(0, sync_odds) == 0);
    end
    trig_in = '0; sync_start = 1'b0;
  endtask

  initial begin
    int  f_edge;
    int  snap[NCH];
    int  b0, d0, guard;
    bit  seen;

    repeat (3) @(negedge clk);
    chk("reset_coax", coax_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sync_done", sync_done, 0);
    chk("reset_dropped", dropped_cnt, 0);
    chk("reset_phase", phase, 0);
    nrst = 1'b1;
    @(negedge clk);

    // Single pulse on channel 2 requested in phase 1.
    for (int c = 0; c < NCH; c++) snap[c] = pulse_cnt[c];
    wait_phase(1);
    trig_in[2] = 1'b1;
    @(negedge clk); trig_in[2] = 1'b0;
    repeat (8) @(negedge clk);
    chk("t1_ch2_pulses", pulse_cnt[2] - snap[2], 1);
    chk("t1_ch0_pulses", pulse_cnt[0] - snap[0], 0);
    chk("t1_dropped", dropped_cnt, 0);

    // Channel 0: fire, retrigger inside holdoff, retrigger after holdoff.
    wait_phase(1);
    f_edge = n + 1 + 3;
    trig_in[0] = 1'b1;
    @(negedge clk); trig_in[0] = 1'b0;
    while (n + 1 != f_edge + 5) @(negedge clk);
    snap[0] = pulse_cnt[0];
    trig_in[0] = 1'b1;
    @(negedge clk); trig_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("t2_holdoff_no_pulse", pulse_cnt[0] - snap[0], 0);
    chk("t2_dropped", dropped_cnt, 1);
    while (n + 1 != f_edge + 20) @(negedge clk);
    trig_in[0] = 1'b1;
    @(negedge clk); trig_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("t2_second_pulse", pulse_cnt[0] - snap[0], 1);

    // Calibration with triggers and a second request during the burst.
    b0 = burst_cnt; d0 = done_cnt;
    sync_start = 1'b1;
    @(negedge clk); sync_start = 1'b0;
    chk("t3_busy_1clk", busy, 0);
    @(negedge clk);
    chk("t3_busy_2clk", busy, 1);
    repeat (QT + 20) @(negedge clk);
    trig_in = '1; sync_start = 1'b1;
    @(negedge clk); trig_in = '0; sync_start = 1'b0;
    for (int i = 0; i < 700 && done_cnt == d0; i++) @(negedge clk);
    chk("t3_sync_done_count", done_cnt - d0, 1);
    chk("t3_burst_pulses", burst_cnt - b0, SP);
    chk("t3_dropped", dropped_cnt, 5);
    @(negedge clk);
    chk("t3_busy_after", busy, 0);

    // Pending request on channel 1 discarded by a calibration request.
    wait_phase(1);
    trig_in[1] = 1'b1; sync_start = 1'b1;
    @(negedge clk); trig_in[1] = 1'b0; sync_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_dropped", dropped_cnt, 6);
    wait_idle();

    // Randomized traffic with occasional calibration requests.
    random_cycles(2500, 300);
    wait_idle();

    // Drive enough lost requests to saturate the counter.
    guard = 0;
    while (m_raw < 65540 && guard < 60000) begin
      @(negedge clk);
      trig_in    = (guard % 2 == 0) ? '1 : '0;
      sync_start = (guard % 500 == 0);
      guard++;
    end
    trig_in = '0; sync_start = 1'b0;
    chk("sat_enough_drops", (m_raw >= 65540) ? 1 : 0, 1);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("sat_dropped", dropped_cnt, 65535);

    // Reset in the middle of a sync burst.
    sync_start = 1'b1;
    @(negedge clk); sync_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 800 && !seen; i++) begin
      @(negedge clk);
      if (&coax_out) seen = 1'b1;
    end
    chk("rst_burst_seen", seen, 1);
    #1 nrst = 1'b0;
    #1;
    chk("rst_coax_now", coax_out, 0);
    chk("rst_busy_now", busy, 0);
    chk("rst_dropped_now", dropped_cnt, 0);
    chk("rst_phase_now", phase, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_busy_after", busy, 0);
    random_cycles(300, 0 + 400);
    repeat (20) @(negedge clk);
    chk("final_coax_queue", coax_q.size(), 0);
    chk("final_done_queue", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
